alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 180 ++++++++++++++++++
 tb/tb_alu_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// ============================================================================
// Module   : alu_unit
// Purpose  : Multi-cycle ALU (add/sub/shift-add mult/lshift) with zero flag.
//            Optional ovf flag output enabled by macro ALU_OVF_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] r_in,
    output logic [WIDTH-1:0] result,
    output logic             z,
`ifdef ALU_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);
    localparam logic [2:0]    c_OP_ADD  = 3'd1;
    localparam logic [2:0]    c_OP_SUB  = 3'd2;
    localparam logic [2:0]    c_OP_MUL  = 3'd3;
    localparam logic [2:0]    c_OP_LSH  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_z;
    logic               r_busy;
    logic               r_done;
`ifdef ALU_OVF_FLAG_EN
    logic               r_ovf;
    logic               w_ovf;
`endif
    logic               w_upd;
    logic [WIDTH-1:0]   w_res;

    // Final result of the captured op; a multiply finishes here from r_acc.
    always_comb begin
        w_upd = 1'b0;
        w_res = r_result;
`ifdef ALU_OVF_FLAG_EN
        w_ovf = r_ovf;
`endif
        case (r_op)
            c_OP_ADD: begin
                w_upd = 1'b1;
`ifdef ALU_OVF_FLAG_EN
                {w_ovf, w_res} = {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_b};
`else
                w_res = r_a[WIDTH-1:0] + r_b;
`endif
            end
            c_OP_SUB: begin
                w_upd = 1'b1;
`ifdef ALU_OVF_FLAG_EN
                {w_ovf, w_res} = {1'b0, r_a[WIDTH-1:0]} - {1'b0, r_b};
`else
                w_res = r_a[WIDTH-1:0] - r_b;
`endif
            end
            c_OP_MUL: begin
                w_upd = 1'b1;
                w_res = r_acc[WIDTH-1:0];
`ifdef ALU_OVF_FLAG_EN
                w_ovf = |r_acc[2*WIDTH-1:WIDTH];
`endif
            end
            c_OP_LSH: begin
                w_upd = 1'b1;
                w_res = {r_a[WIDTH-2:0], 1'b0};
`ifdef ALU_OVF_FLAG_EN
                w_ovf = r_a[WIDTH-1];
`endif
            end
            default: begin
                w_upd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 3'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_z      <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= alu_op;
                        r_a     <= {{WIDTH{1'b0}}, ac_in};
                        r_b     <= r_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (alu_op == c_OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_MUL: begin
                    // One multiplier bit per cycle, multiplicand shifted up.
                    if (r_b[0]) begin
                        r_acc <= r_acc + r_a;
                    end
                    r_a <= r_a << 1;
                    r_b <= r_b >> 1;
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_upd) begin
                        r_result <= w_res;
                        r_z      <= (w_res == '0);
`ifdef ALU_OVF_FLAG_EN
                        r_ovf    <= w_ovf;
`endif
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign z      = r_z;
    assign busy   = r_busy;
    assign done   = r_done;
`ifdef ALU_OVF_FLAG_EN
    assign ovf    = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
// ============================================================================
// Module   : tb_alu_unit
// Purpose  : Scoreboard bench for alu_unit: random and directed ops checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   alu_op = 3'd0;
    logic [W-1:0] ac_in = '0;
    logic [W-1:0] r_in = '0;
    logic [W-1:0] result;
    logic         z;
    logic         busy;
    logic         done;
`ifdef ALU_OVF_FLAG_EN
    logic         ovf;
`endif

    alu_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .ac_in  (ac_in),
        .r_in   (r_in),
        .result (result),
        .z      (z),
`ifdef ALU_OVF_FLAG_EN
        .ovf    (ovf),
`endif
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         zf;
        logic         of;
        int           cap;
        int           lat;
    } exp_t;

    exp_t   sb[$];
    int     cyc = 0;
    int     vectors = 0;
    int     errors = 0;
    int     dones_seen = 0;
    int     issued = 0;
    int     busy_run = 0;

    logic [W-1:0] m_res = '0;
    logic         m_z = 1'b1;
    logic         m_of = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the captured operands.
    task automatic push_exp(input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int k);
        longint full;
        exp_t   e;
        case (op)
            3'd1: begin full = longint'(a) + longint'(b); m_of = (full >= (64'd1 << W)); end
            3'd2: begin full = longint'(a) - longint'(b); m_of = (a < b); end
            3'd3: begin full = longint'(a) * longint'(b); m_of = ((full >> W) != 0); end
            3'd4: begin full = longint'(a) * 2;           m_of = a[W-1]; end
            default: full = -1;
        endcase
        if (op >= 3'd1 && op <= 3'd4) begin
            m_res = W'(full);
            m_z   = (m_res == 0);
        end
        e.res = m_res;
        e.zf  = m_z;
        e.of  = m_of;
        e.cap = k;
        e.lat = (op == 3'd3) ? W + 1 : 1;
        sb.push_back(e);
        issued++;
    endtask

    // Monitor: every done pulse pops and checks one expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_run <= 0;
        end else begin
            if (busy) busy_run <= busy_run + 1;
            else      busy_run <= 0;
            if (done) begin
                dones_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("zero_flag", z, e.zf);
`ifdef ALU_OVF_FLAG_EN
                    check("ovf_flag", ovf, e.of);
`endif
                    check("done_latency", cyc - e.cap, e.lat);
                    check("busy_cycles", busy_run + 1, e.lat + 1);
                end
            end
        end
    end

    // Wait for IDLE; optionally fire ignored start pulses while busy.
    task automatic wait_idle(input bit poke);
        int guard = 0;
        @(negedge clk);
        while (busy) begin
            if (poke && !start && ($urandom_range(0, 3) == 0)) begin
                start  = 1'b1;
                alu_op = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            ac_in = W'($urandom);
            r_in  = W'($urandom);
            guard++;
            if (guard > 200) begin
                check("idle_timeout", guard, 0);
                $fatal(1, "FAIL idle_timeout: DUT stuck busy");
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke);
        wait_idle(1'b0);
        alu_op = op;
        ac_in  = a;
        r_in   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        push_exp(op, a, b, cyc);
        @(negedge clk);
        start = 1'b0;
        ac_in = W'($urandom);
        r_in  = W'($urandom);
        if (poke) wait_idle(1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_result", result, 0);
        check("rst_z", z, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef ALU_OVF_FLAG_EN
        check("rst_ovf", ovf, 0);
`endif

        issue(3'd1, 16'h0003, 16'h0004, 1'b0);
        issue(3'd2, 16'h1234, 16'h1234, 1'b0);
        issue(3'd2, 16'h0000, 16'h0001, 1'b0);
        issue(3'd3, 16'h0012, 16'h0034, 1'b1);
        issue(3'd3, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(3'd4, 16'h8001, 16'h0000, 1'b0);
        issue(3'd0, 16'h5555, 16'hAAAA, 1'b0);
        issue(3'd7, 16'h0000, 16'h0000, 1'b1);

        // Reset during iteration 8 of a multiply: abort, no done pulse.
        issue(3'd3, 16'h00FF, 16'h0F0F, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_z", z, 1);
        sb.delete();
        issued--;
        m_res = '0; m_z = 1'b1; m_of = 1'b0;
        issue(3'd1, 16'h0100, 16'h0023, 1'b0);

        // start held high: back-to-back ops one IDLE cycle apart.
        wait_idle(1'b0);
        alu_op = 3'd1; ac_in = 16'hFFFF; r_in = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        push_exp(3'd1, 16'hFFFF, 16'h0001, k);
        repeat (3) @(posedge clk);
        #1;
        push_exp(3'd1, 16'hFFFF, 16'h0001, k + 3);
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if (i % 8 == 0) b = '0;
            if (i % 8 == 1) a = b;
            issue(3'($urandom_range(0, 7)), a, b, 1'(i % 2));
        end

        wait_idle(1'b0);
        repeat (3) @(negedge clk);
        check("pending_expectations", sb.size(), 0);
        check("done_count", dones_seen, issued);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
